ifm_write_ctrl_u6_d16_s5: RTL and testbench
===========================================

IFM_WRITE_CTRL_U6_D16_S5 -- requirements
Module: ifm_write_ctrl_U6_D16_S5

Parameters
REQ-001 DATA_WIDTH, 32, width of each data lane.
REQ-002 IFM_SIZE, 5, feature-map side; one map holds IFM_SIZE*IFM_SIZE = 25 pixels.
REQ-003 NUMBER_OF_IFM, 16, maps per layer.
REQ-004 NUMBER_OF_UNITS, 6, parallel lanes; map groups G = ceil(16/6) = 3, last group uses lanes 1-4.
REQ-005 ADDRESS_SIZE_IFM, $clog2(IFM_SIZE*IFM_SIZE) = 5, pixel address width.

Interface
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 start  in  1  one-cycle pulse; begins a layer; ignored unless in IDLE.
REQ-009 valid_in  in  1  upstream pixel-column valid.
REQ-010 data_in1..data_in6  in  DATA_WIDTH each  lane data, one pixel per lane.
REQ-011 ready_out  out  1  accept; transfer occurs when valid_in & ready_out.
REQ-012 next_read_done  in  1  one-cycle pulse from downstream: read of current bank finished.
REQ-013 ifm_sel  out  2  bank select to memory array: 0 writes bank 1 (maps 1-6), 1 writes bank 2 (maps 7-12), 2 writes bank 3 (maps 13-16); downstream reads bank (ifm_sel+2) mod 3.
REQ-014 ifm_enable_write_previous  out  1  memory write enable.
REQ-015 ifm_address_write_previous  out  ADDRESS_SIZE_IFM  memory write address.
REQ-016 data_in_from_previous1..6  out  DATA_WIDTH each  registered write data to memory.
REQ-017 next_start  out  1  one-cycle pulse: a complete group is readable by downstream.
REQ-018 layer_done  out  1  one-cycle pulse: last group written and read.

Function
REQ-019 States SHALL be IDLE, WRITE, HOLD, DRAIN.
REQ-020 IDLE: ready_out=0; on start -> WRITE with pixel counter=0, group counter=0, ifm_sel=0.
REQ-021 WRITE: ready_out=1; each transfer increments pixel counter 0..24.
REQ-022 Write path latency SHALL be exactly 1 cycle: cycle after a transfer, enable=1, address=accepted pixel index, data=registered lane data; otherwise enable=0, address and data hold.
REQ-023 In group G-1, data_in_from_previous5 and 6 SHALL be driven 0.
REQ-024 On transfer of pixel 24: pixel counter wraps to 0, next state HOLD.
REQ-025 read_pending flag: set on next_start, cleared on next_read_done; next_read_done while clear is ignored.
REQ-026 HOLD: ready_out=0; advance when read_pending=0 or next_read_done=1 in the same cycle.
REQ-027 On advance: ifm_sel <= (ifm_sel+1) mod 3, group counter +1, next_start pulses the same cycle the new ifm_sel becomes visible; if group counter was < G-1 -> WRITE, else -> DRAIN.
REQ-028 Advance SHALL occur only after the final write of the group has been issued (last enable cycle precedes or coincides with HOLD entry).
REQ-029 DRAIN: ready_out=0; on next_read_done -> layer_done pulse one cycle, -> IDLE; ifm_sel stays 0.
REQ-030 Simultaneous set and clear of read_pending (next_start and next_read_done same cycle) SHALL leave read_pending=1.
REQ-031 start received outside IDLE SHALL have no effect.

Reset
REQ-032 rst_n low SHALL immediately force: state IDLE, ifm_sel=0, counters=0, read_pending=0, ready_out=0, enable=0, address=0, data outputs=0, next_start=0, layer_done=0.
REQ-033 Reset mid-layer SHALL abandon the layer; no pulses emitted until a new start.

Verification
REQ-034 Reset then start, 25 back-to-back transfers with data_in1=pixel index -> addresses 0..24 with enable one cycle after each transfer, ifm_sel=0, next_start one cycle after HOLD entry, ifm_sel=1.
REQ-035 valid_in toggled every other cycle during group -> only accepted pixels written, addresses contiguous, no gaps in address sequence.
REQ-036 Group 1 complete without next_read_done -> ready_out=0 held indefinitely; pulse next_read_done -> advance same cycle, ifm_sel=2.
REQ-037 Full layer, 75 transfers, read_done pulses after each next_start -> ifm_sel 0,1,2,0; lanes 5-6 write 0 in group 3; layer_done exactly once after final read_done.
REQ-038 next_start and next_read_done coincident -> read_pending remains 1; next group blocked until a further read_done.
REQ-039 rst_n asserted at pixel 12 of group 2 -> all outputs 0 same cycle; after release, start resumes at ifm_sel=0, address 0.

Source files
------------

// File: rtl/ifm_write_ctrl_u6_d16_s5_if.sv
// Bus bundle between the IFM write controller, its upstream pixel source,
// the banked IFM memory and the downstream reader.
interface ifm_write_ctrl_u6_d16_s5_if #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDRESS_SIZE_IFM = 5
);
  logic                        start;
  logic                        valid_in;
  logic                        ready_out;
  logic                        next_read_done;
  logic [DATA_WIDTH-1:0]       data_in1;
  logic [DATA_WIDTH-1:0]       data_in2;
  logic [DATA_WIDTH-1:0]       data_in3;
  logic [DATA_WIDTH-1:0]       data_in4;
  logic [DATA_WIDTH-1:0]       data_in5;
  logic [DATA_WIDTH-1:0]       data_in6;
  logic [1:0]                  ifm_sel;
  logic                        ifm_enable_write_previous;
  logic [ADDRESS_SIZE_IFM-1:0] ifm_address_write_previous;
  logic [DATA_WIDTH-1:0]       data_in_from_previous1;
  logic [DATA_WIDTH-1:0]       data_in_from_previous2;
  logic [DATA_WIDTH-1:0]       data_in_from_previous3;
  logic [DATA_WIDTH-1:0]       data_in_from_previous4;
  logic [DATA_WIDTH-1:0]       data_in_from_previous5;
  logic [DATA_WIDTH-1:0]       data_in_from_previous6;
  logic                        next_start;
  logic                        layer_done;

  // Environment side: pixel source, downstream reader and memory observer.
  modport master (
    output start, valid_in, next_read_done,
    output data_in1, data_in2, data_in3, data_in4, data_in5, data_in6,
    input  ready_out, ifm_sel, ifm_enable_write_previous, ifm_address_write_previous,
    input  data_in_from_previous1, data_in_from_previous2, data_in_from_previous3,
    input  data_in_from_previous4, data_in_from_previous5, data_in_from_previous6,
    input  next_start, layer_done
  );

  modport slave (
    input  start, valid_in, next_read_done,
    input  data_in1, data_in2, data_in3, data_in4, data_in5, data_in6,
    output ready_out, ifm_sel, ifm_enable_write_previous, ifm_address_write_previous,
    output data_in_from_previous1, data_in_from_previous2, data_in_from_previous3,
    output data_in_from_previous4, data_in_from_previous5, data_in_from_previous6,
    output next_start, layer_done
  );
endinterface

// File: rtl/ifm_write_ctrl_u6_d16_s5.sv
// IFM write controller: streams 6-lane pixel columns into a triple-buffered
// IFM memory, one map group per bank, handshaking bank hand-over downstream.
module ifm_write_ctrl_u6_d16_s5 #(
  parameter int DATA_WIDTH       = 32,
  parameter int IFM_SIZE         = 5,
  parameter int NUMBER_OF_IFM    = 16,
  parameter int NUMBER_OF_UNITS  = 6,
  parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE*IFM_SIZE)
) (
  input logic                        clk,
  input logic                        rst_n,
  ifm_write_ctrl_u6_d16_s5_if.slave  bus
);
  localparam int PIXELS     = IFM_SIZE*IFM_SIZE;
  localparam int GROUPS     = (NUMBER_OF_IFM + NUMBER_OF_UNITS - 1) / NUMBER_OF_UNITS;
  localparam int LAST_LANES = NUMBER_OF_IFM - (GROUPS-1)*NUMBER_OF_UNITS;
  localparam logic [ADDRESS_SIZE_IFM-1:0] LAST_PIXEL = ADDRESS_SIZE_IFM'(PIXELS-1);
  localparam logic [1:0] LAST_GROUP = 2'(GROUPS-1);

  typedef enum logic [1:0] {IDLE, WRITE, HOLD, DRAIN} state_t;

  state_t                      state;
  state_t                      next_state;
  logic [ADDRESS_SIZE_IFM-1:0] pix_cnt;
  logic [1:0]                  grp_cnt;
  logic [1:0]                  ifm_sel_q;
  logic                        read_pending;
  logic                        next_start_q;
  logic                        layer_done_q;
  logic                        enable_q;
  logic [ADDRESS_SIZE_IFM-1:0] address_q;
  logic [DATA_WIDTH-1:0]       lane_in [NUMBER_OF_UNITS];
  logic [DATA_WIDTH-1:0]       lane_q  [NUMBER_OF_UNITS];

  logic ready;
  logic take;
  logic advance;
  logic finish;
  logic begin_layer;

  assign lane_in[0] = bus.data_in1;
  assign lane_in[1] = bus.data_in2;
  assign lane_in[2] = bus.data_in3;
  assign lane_in[3] = bus.data_in4;
  assign lane_in[4] = bus.data_in5;
  assign lane_in[5] = bus.data_in6;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A bank may only be handed over once the reader has released the previous
  // one; a read_done arriving in the same cycle counts as that release.
  always_comb begin
    next_state  = state;
    ready       = 1'b0;
    take        = 1'b0;
    advance     = 1'b0;
    finish      = 1'b0;
    begin_layer = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          begin_layer = 1'b1;
          next_state  = WRITE;
        end
      end
      WRITE: begin
        ready = 1'b1;
        take  = bus.valid_in;
        if (bus.valid_in && pix_cnt == LAST_PIXEL) begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (!read_pending || bus.next_read_done) begin
          advance    = 1'b1;
          next_state = (grp_cnt == LAST_GROUP) ? DRAIN : WRITE;
        end
      end
      DRAIN: begin
        if (bus.next_read_done) begin
          finish     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt      <= '0;
      grp_cnt      <= '0;
      ifm_sel_q    <= '0;
      read_pending <= 1'b0;
      next_start_q <= 1'b0;
      layer_done_q <= 1'b0;
    end else begin
      next_start_q <= advance;
      layer_done_q <= finish;
      if (begin_layer) begin
        pix_cnt   <= '0;
        grp_cnt   <= '0;
        ifm_sel_q <= '0;
      end else begin
        if (take) begin
          pix_cnt <= (pix_cnt == LAST_PIXEL) ? '0 : pix_cnt + ADDRESS_SIZE_IFM'(1);
        end
        if (advance) begin
          grp_cnt   <= grp_cnt + 2'd1;
          ifm_sel_q <= (ifm_sel_q == LAST_GROUP) ? 2'd0 : ifm_sel_q + 2'd1;
        end
      end
      // Set wins over clear so a bank announced this cycle is never lost.
      if (next_start_q) begin
        read_pending <= 1'b1;
      end else if (bus.next_read_done) begin
        read_pending <= 1'b0;
      end
    end
  end

  // Memory write port lags the handshake by one cycle; unused lanes of the
  // last group write zero so stale maps never leak into the bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q  <= 1'b0;
      address_q <= '0;
      for (int i = 0; i < NUMBER_OF_UNITS; i++) begin
        lane_q[i] <= '0;
      end
    end else begin
      enable_q <= take;
      if (take) begin
        address_q <= pix_cnt;
        for (int i = 0; i < NUMBER_OF_UNITS; i++) begin
          if (grp_cnt == LAST_GROUP && i >= LAST_LANES) begin
            lane_q[i] <= '0;
          end else begin
            lane_q[i] <= lane_in[i];
          end
        end
      end
    end
  end

  assign bus.ready_out                  = ready;
  assign bus.ifm_sel                    = ifm_sel_q;
  assign bus.ifm_enable_write_previous  = enable_q;
  assign bus.ifm_address_write_previous = address_q;
  assign bus.data_in_from_previous1     = lane_q[0];
  assign bus.data_in_from_previous2     = lane_q[1];
  assign bus.data_in_from_previous3     = lane_q[2];
  assign bus.data_in_from_previous4     = lane_q[3];
  assign bus.data_in_from_previous5     = lane_q[4];
  assign bus.data_in_from_previous6     = lane_q[5];
  assign bus.next_start                 = next_start_q;
  assign bus.layer_done                 = layer_done_q;

endmodule

// File: tb/tb_ifm_write_ctrl_u6_d16_s5.sv
// Directed bench for the IFM write controller: bank rotation, write-path
// latency, read_pending blocking, lane zeroing, drain and mid-layer reset.
module tb_ifm_write_ctrl_u6_d16_s5;
  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  ifm_write_ctrl_u6_d16_s5_if #(.DATA_WIDTH(32), .ADDRESS_SIZE_IFM(5)) bus ();

  ifm_write_ctrl_u6_d16_s5 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one column (lane k carries value+k-1) and advances one clock.
  task automatic applyStimulus(input logic vld, input logic [31:0] value);
    bus.valid_in = vld;
    bus.data_in1 = value;
    bus.data_in2 = value + 32'd1;
    bus.data_in3 = value + 32'd2;
    bus.data_in4 = value + 32'd3;
    bus.data_in5 = value + 32'd4;
    bus.data_in6 = value + 32'd5;
    step();
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.start          = 1'b0;
    bus.valid_in       = 1'b0;
    bus.next_read_done = 1'b0;
    bus.data_in1 = '0; bus.data_in2 = '0; bus.data_in3 = '0;
    bus.data_in4 = '0; bus.data_in5 = '0; bus.data_in6 = '0;
    #12;
    checkOutput("rst_ready", 32'(bus.ready_out), 32'd0);
    checkOutput("rst_en", 32'(bus.ifm_enable_write_previous), 32'd0);
    checkOutput("rst_addr", 32'(bus.ifm_address_write_previous), 32'd0);
    checkOutput("rst_sel", 32'(bus.ifm_sel), 32'd0);
    checkOutput("rst_nstart", 32'(bus.next_start), 32'd0);
    checkOutput("rst_ldone", 32'(bus.layer_done), 32'd0);
    checkOutput("rst_data1", bus.data_in_from_previous1, 32'd0);
    rst_n = 1'b1;
    step();
    checkOutput("idle_ready", 32'(bus.ready_out), 32'd0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checkOutput("write_ready", 32'(bus.ready_out), 32'd1);

    // Group 0: back-to-back transfers, data_in1 = pixel index.
    for (int p = 0; p < 25; p++) begin
      applyStimulus(1'b1, 32'(p));
      checkOutput("g0_en", 32'(bus.ifm_enable_write_previous), 32'd1);
      checkOutput("g0_addr", 32'(bus.ifm_address_write_previous), 32'(p));
      checkOutput("g0_d1", bus.data_in_from_previous1, 32'(p));
      checkOutput("g0_d6", bus.data_in_from_previous6, 32'(p + 5));
      checkOutput("g0_sel", 32'(bus.ifm_sel), 32'd0);
    end
    checkOutput("g0_hold_ready", 32'(bus.ready_out), 32'd0);
    checkOutput("g0_hold_nstart", 32'(bus.next_start), 32'd0);
    bus.valid_in = 1'b0;
    step();
    checkOutput("g0_adv_nstart", 32'(bus.next_start), 32'd1);
    checkOutput("g0_adv_sel", 32'(bus.ifm_sel), 32'd1);
    checkOutput("g0_adv_en", 32'(bus.ifm_enable_write_previous), 32'd0);
    checkOutput("g0_adv_addr", 32'(bus.ifm_address_write_previous), 32'd24);
    checkOutput("g0_adv_ready", 32'(bus.ready_out), 32'd1);

    // Group 1: valid every other cycle; skipped cycles must hold the write port.
    for (int k = 0; k < 49; k++) begin
      if (k % 2 == 0) begin
        applyStimulus(1'b1, 32'(200 + k/2));
        checkOutput("g1_en", 32'(bus.ifm_enable_write_previous), 32'd1);
      end else begin
        applyStimulus(1'b0, 32'hDEAD0000 + 32'(k));
        checkOutput("g1_idle_en", 32'(bus.ifm_enable_write_previous), 32'd0);
      end
      checkOutput("g1_addr", 32'(bus.ifm_address_write_previous), 32'(k/2));
      checkOutput("g1_d1", bus.data_in_from_previous1, 32'(200 + k/2));
      checkOutput("g1_nstart", 32'(bus.next_start), 32'd0);
    end
    bus.valid_in = 1'b0;
    repeat (8) begin
      step();
      checkOutput("g1_block_ready", 32'(bus.ready_out), 32'd0);
      checkOutput("g1_block_nstart", 32'(bus.next_start), 32'd0);
      checkOutput("g1_block_sel", 32'(bus.ifm_sel), 32'd1);
    end
    bus.next_read_done = 1'b1;
    step();
    bus.next_read_done = 1'b0;
    checkOutput("g1_adv_nstart", 32'(bus.next_start), 32'd1);
    checkOutput("g1_adv_sel", 32'(bus.ifm_sel), 32'd2);
    checkOutput("g1_adv_ready", 32'(bus.ready_out), 32'd1);

    // Group 2: read_done coincides with next_start; lanes 5-6 must write zero;
    // a stray start mid-group must not disturb the address sequence.
    bus.next_read_done = 1'b1;
    applyStimulus(1'b1, 32'd300);
    bus.next_read_done = 1'b0;
    checkOutput("g2_addr0", 32'(bus.ifm_address_write_previous), 32'd0);
    checkOutput("g2_d1", bus.data_in_from_previous1, 32'd300);
    checkOutput("g2_d4", bus.data_in_from_previous4, 32'd303);
    checkOutput("g2_d5", bus.data_in_from_previous5, 32'd0);
    checkOutput("g2_d6", bus.data_in_from_previous6, 32'd0);
    for (int p = 1; p < 25; p++) begin
      bus.start = (p == 10);
      applyStimulus(1'b1, 32'(300 + p));
      checkOutput("g2_addr", 32'(bus.ifm_address_write_previous), 32'(p));
      checkOutput("g2_lane5", bus.data_in_from_previous5, 32'd0);
      checkOutput("g2_lane6", bus.data_in_from_previous6, 32'd0);
      checkOutput("g2_lane2", bus.data_in_from_previous2, 32'(301 + p));
    end
    bus.start    = 1'b0;
    bus.valid_in = 1'b0;
    repeat (4) begin
      step();
      checkOutput("g2_block_nstart", 32'(bus.next_start), 32'd0);
      checkOutput("g2_block_sel", 32'(bus.ifm_sel), 32'd2);
      checkOutput("g2_block_ready", 32'(bus.ready_out), 32'd0);
    end
    bus.next_read_done = 1'b1;
    step();
    bus.next_read_done = 1'b0;
    checkOutput("g2_adv_nstart", 32'(bus.next_start), 32'd1);
    checkOutput("g2_adv_sel", 32'(bus.ifm_sel), 32'd0);
    checkOutput("g2_adv_ready", 32'(bus.ready_out), 32'd0);
    checkOutput("g2_adv_ldone", 32'(bus.layer_done), 32'd0);

    // Drain: layer_done only on the final read_done, exactly one cycle.
    repeat (3) begin
      step();
      checkOutput("drain_ldone", 32'(bus.layer_done), 32'd0);
      checkOutput("drain_nstart", 32'(bus.next_start), 32'd0);
      checkOutput("drain_ready", 32'(bus.ready_out), 32'd0);
    end
    bus.next_read_done = 1'b1;
    step();
    bus.next_read_done = 1'b0;
    checkOutput("done_pulse", 32'(bus.layer_done), 32'd1);
    checkOutput("done_sel", 32'(bus.ifm_sel), 32'd0);
    step();
    checkOutput("done_clear", 32'(bus.layer_done), 32'd0);
    checkOutput("done_idle_ready", 32'(bus.ready_out), 32'd0);

    // Second layer, reset at pixel 12 of the second group.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int p = 0; p < 25; p++) begin
      applyStimulus(1'b1, 32'(500 + p));
    end
    bus.valid_in = 1'b0;
    step();
    checkOutput("l2_adv_sel", 32'(bus.ifm_sel), 32'd1);
    checkOutput("l2_adv_nstart", 32'(bus.next_start), 32'd1);
    for (int p = 0; p < 13; p++) begin
      applyStimulus(1'b1, 32'(600 + p));
    end
    checkOutput("l2_pre_addr", 32'(bus.ifm_address_write_previous), 32'd12);
    checkOutput("l2_pre_d6", bus.data_in_from_previous6, 32'd617);
    rst_n        = 1'b0;
    bus.valid_in = 1'b0;
    #1;
    checkOutput("mid_rst_ready", 32'(bus.ready_out), 32'd0);
    checkOutput("mid_rst_en", 32'(bus.ifm_enable_write_previous), 32'd0);
    checkOutput("mid_rst_addr", 32'(bus.ifm_address_write_previous), 32'd0);
    checkOutput("mid_rst_d1", bus.data_in_from_previous1, 32'd0);
    checkOutput("mid_rst_d6", bus.data_in_from_previous6, 32'd0);
    checkOutput("mid_rst_sel", 32'(bus.ifm_sel), 32'd0);
    checkOutput("mid_rst_nstart", 32'(bus.next_start), 32'd0);
    checkOutput("mid_rst_ldone", 32'(bus.layer_done), 32'd0);
    rst_n = 1'b1;
    repeat (3) begin
      step();
      checkOutput("post_rst_nstart", 32'(bus.next_start), 32'd0);
      checkOutput("post_rst_ldone", 32'(bus.layer_done), 32'd0);
      checkOutput("post_rst_ready", 32'(bus.ready_out), 32'd0);
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checkOutput("restart_ready", 32'(bus.ready_out), 32'd1);
    applyStimulus(1'b1, 32'd7);
    bus.valid_in = 1'b0;
    checkOutput("restart_en", 32'(bus.ifm_enable_write_previous), 32'd1);
    checkOutput("restart_addr", 32'(bus.ifm_address_write_previous), 32'd0);
    checkOutput("restart_d1", bus.data_in_from_previous1, 32'd7);
    checkOutput("restart_sel", 32'(bus.ifm_sel), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
